// File: rtl/clk_div_bank.sv
// ---------------------------------------------------------------------------
// clk_div_bank
// Bank of N_CH independent programmable clock dividers plus one fixed-ratio
// divider. Each programmable channel toggles clk_out after act+1 cycles per
// half-period. A written divisor is held in a shadow register and applied at
// the next period boundary (the cycle before a rising edge), or immediately
// when the channel is disabled, so no runt pulses are produced.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   wr_en_i    divisor write strobe (one cycle per write)
//   wr_ch_i    channel index for the write; indices >= N_CH are ignored
//   wr_data_i  new divisor value
//   ch_en_i    per-channel run enable
//   clk_out_o  divided square waves
//   rise_o     one-cycle strobe coincident with clk_out_o 0->1
//   pending_o  a written divisor is waiting to be applied
//   clk_fix_o  fixed-ratio square wave (half-period FIX_DIV+1 cycles)
// ---------------------------------------------------------------------------
module clk_div_bank #(
   parameter int N_CH    = 4,
   parameter int DIV_W   = 16,
   parameter int RST_DIV = 1,
   parameter int FIX_DIV = 49999,
   parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [CH_W-1:0]  wr_ch_i,
   input  logic [DIV_W-1:0] wr_data_i,
   input  logic [N_CH-1:0]  ch_en_i,
   output logic [N_CH-1:0]  clk_out_o,
   output logic [N_CH-1:0]  rise_o,
   output logic [N_CH-1:0]  pending_o,
   output logic             clk_fix_o
);

   localparam logic [DIV_W-1:0] RST_VAL = DIV_W'(RST_DIV);
   localparam logic [DIV_W-1:0] FIX_TC  = DIV_W'(FIX_DIV);

   logic [DIV_W-1:0] cnt_q    [N_CH];
   logic [DIV_W-1:0] cnt_d    [N_CH];
   logic [DIV_W-1:0] act_q    [N_CH];
   logic [DIV_W-1:0] act_d    [N_CH];
   logic [DIV_W-1:0] shadow_q [N_CH];
   logic [DIV_W-1:0] shadow_d [N_CH];
   logic [N_CH-1:0]  clk_q, clk_d;
   logic [N_CH-1:0]  rise_q, rise_d;
   logic [N_CH-1:0]  pend_q, pend_d;
   logic [N_CH-1:0]  wr_sel;
   logic [N_CH-1:0]  apply;

   logic [DIV_W-1:0] fix_cnt_q, fix_cnt_d;
   logic             fix_q, fix_d;

   logic [31:0]      wr_ch_ext;

   // Zero-extended index so that out-of-range channels simply match nothing.
   assign wr_ch_ext = 32'(wr_ch_i);

   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < N_CH; i++) begin
         wr_sel[i] = wr_en_i && (wr_ch_ext == 32'(i));
      end
   end

   always_comb begin
      apply = '0;
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i]    = cnt_q[i];
         act_d[i]    = act_q[i];
         shadow_d[i] = shadow_q[i];
         clk_d[i]    = clk_q[i];
         rise_d[i]   = 1'b0;
         pend_d[i]   = pend_q[i];

         if (ch_en_i[i]) begin
            if (cnt_q[i] == act_q[i]) begin
               cnt_d[i]  = '0;
               clk_d[i]  = ~clk_q[i];
               rise_d[i] = ~clk_q[i];
               // Boundary: terminal count while low, next edge is rising.
               apply[i]  = ~clk_q[i] & pend_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
         end else begin
            cnt_d[i] = '0;
            clk_d[i] = 1'b0;
            apply[i] = pend_q[i];
         end

         // Apply uses the shadow value held before this cycle; a write in the
         // same cycle then re-arms pending for the following boundary.
         if (apply[i]) begin
            act_d[i]  = shadow_q[i];
            pend_d[i] = 1'b0;
         end
         if (wr_sel[i]) begin
            shadow_d[i] = wr_data_i;
            pend_d[i]   = 1'b1;
         end
      end
   end

   always_comb begin
      fix_cnt_d = fix_cnt_q + DIV_W'(1);
      fix_d     = fix_q;
      if (fix_cnt_q == FIX_TC) begin
         fix_cnt_d = '0;
         fix_d     = ~fix_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i]    <= '0;
            act_q[i]    <= RST_VAL;
            shadow_q[i] <= RST_VAL;
         end
         clk_q     <= '0;
         rise_q    <= '0;
         pend_q    <= '0;
         fix_cnt_q <= '0;
         fix_q     <= 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i]    <= cnt_d[i];
            act_q[i]    <= act_d[i];
            shadow_q[i] <= shadow_d[i];
         end
         clk_q     <= clk_d;
         rise_q    <= rise_d;
         pend_q    <= pend_d;
         fix_cnt_q <= fix_cnt_d;
         fix_q     <= fix_d;
      end
   end

   assign clk_out_o = clk_q;
   assign rise_o    = rise_q;
   assign pending_o = pend_q;
   assign clk_fix_o = fix_q;

endmodule
